// File: rtl/hydro_pkg.sv
// Shared types for the hydrophone frame transmit path.
package hydro_pkg;

    localparam int DEFAULT_CH_WIDTH = 16;
    localparam int NUM_CH           = 4;

    // One 4-channel sample set; ch0 occupies the least significant bits.
    typedef struct packed {
        logic [DEFAULT_CH_WIDTH-1:0] ch3;
        logic [DEFAULT_CH_WIDTH-1:0] ch2;
        logic [DEFAULT_CH_WIDTH-1:0] ch1;
        logic [DEFAULT_CH_WIDTH-1:0] ch0;
    } hydro_frame_t;

    // Position within the 2-beat AXIS frame.
    typedef enum logic {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } beat_e;

endpackage

// File: rtl/hydro_frame_fifo.sv
// Synchronous frame FIFO. Pointers carry one extra wrap bit to separate full from empty.
module hydro_frame_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = hydro_pkg::hydro_frame_t
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; reset discards every queued frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hydro_frame_tx.sv
// Packs 4-channel hydrophone samples into 2-beat AXIS frames, with window and drop counters.
module hydro_frame_tx #(
    parameter int CH_WIDTH   = hydro_pkg::DEFAULT_CH_WIDTH,
    parameter int FIFO_DEPTH = 2,
    parameter int WINDOW     = 500
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [CH_WIDTH-1:0]   ch0_data,
    input  logic [CH_WIDTH-1:0]   ch1_data,
    input  logic [CH_WIDTH-1:0]   ch2_data,
    input  logic [CH_WIDTH-1:0]   ch3_data,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [2*CH_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  window_done,
    output logic [15:0]           drop_count
);

    import hydro_pkg::*;

    // Same layout as hydro_frame_t, sized by this instance's CH_WIDTH.
    typedef struct packed {
        logic [CH_WIDTH-1:0] ch3;
        logic [CH_WIDTH-1:0] ch2;
        logic [CH_WIDTH-1:0] ch1;
        logic [CH_WIDTH-1:0] ch0;
    } frame_t;

    localparam int            CW       = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

    logic          running;
    beat_e         beat;
    logic [CW-1:0] frame_cnt;

    frame_t        wr_frame;
    frame_t        head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          handshake;

    assign wr_frame = '{ch3: ch3_data, ch2: ch2_data, ch1: ch1_data, ch0: ch0_data};

    // running holds sample_ready low until the first edge after reset release.
    assign sample_ready  = running && !fifo_full;
    assign push          = sample_valid && sample_ready;
    assign m_axis_tvalid = !fifo_empty;
    assign handshake     = m_axis_tvalid && m_axis_tready;
    assign pop           = handshake && (beat == BEAT1);

    hydro_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (frame_t)
    ) u_fifo (
        .clk     (m_axis_aclk),
        .resetn  (m_axis_aresetn),
        .push    (push),
        .wr_data (wr_frame),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    // Beat select from FIFO head; zero whenever nothing is queued.
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        if (!fifo_empty) begin
            if (beat == BEAT0) begin
                m_axis_tdata = {head.ch1, head.ch0};
            end else begin
                m_axis_tdata = {head.ch3, head.ch2};
                m_axis_tlast = 1'b1;
            end
        end
    end

    // Reset-release flag gating sample_ready.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) running <= 1'b0;
        else                 running <= 1'b1;
    end

    // Beat sequencer: advances only on an AXIS handshake.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            beat <= BEAT0;
        end else if (handshake) begin
            beat <= (beat == BEAT0) ? BEAT1 : BEAT0;
        end
    end

    // Frame counter per window; window_done pulses the cycle after the last frame completes.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            frame_cnt   <= '0;
            window_done <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (pop) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    window_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end
    end

    // Saturating count of refused sample offers.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            drop_count <= '0;
        end else if (sample_valid && !sample_ready && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule
